// File: rtl/grant_decoder.sv
// Registered 3-to-8 grant decoder: captures the encoder's winning index, holds a one-hot
// grant until ack, then inserts a one-cycle gap. Optional hold timeout: GRANT_DECODER_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for in_valid; in_ready=1, no grant driven
// S_GRANT | one-hot grant on out for the captured index, waiting for ack
// S_GAP   | one dead cycle after a grant; done/timeout pulse lives here
module grant_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_idx,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ack,
    output logic [7:0] out,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state;

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("grant_decoder: HOLD_CYCLES out of range 1..255");
    end

    assign in_ready = (state == S_IDLE);

`ifdef GRANT_DECODER_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out       <= 8'h00;
            grant_idx <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state     <= S_GRANT;
                        grant_idx <= in_idx;
                        out       <= 8'b1 << in_idx;
                        busy      <= 1'b1;
`ifdef GRANT_DECODER_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    // ack takes precedence over an expiring hold counter
                    if (ack) begin
                        state <= S_GAP;
                        out   <= 8'h00;
                        done  <= 1'b1;
                    end
`ifdef GRANT_DECODER_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        state     <= S_GAP;
                        out       <= 8'h00;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    out   <= 8'h00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: cycle model compared every cycle, plus
// directed vectors with literal expectations. Honours GRANT_DECODER_TIMEOUT_EN.
module tb_grant_decoder;

    localparam int HOLD = 4;
`ifdef GRANT_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_idx = 3'd0;
    logic       in_valid = 1'b0;
    logic       ack = 1'b0;
    logic       in_ready;
    logic [7:0] out;
    logic [2:0] grant_idx;
    logic       busy, done, timeout;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    grant_decoder #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
        .in_ready(in_ready), .ack(ack), .out(out), .grant_idx(grant_idx),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: granted flag, count of grant cycles already shown, gap flag.
    bit         m_granted = 0, m_gap = 0;
    int         m_shown = 0;
    logic [2:0] m_idx = 0;
    bit         m_done = 0, m_to = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_granted = 0; m_gap = 0; m_shown = 0; m_idx = 0; m_done = 0; m_to = 0;
        end else if (m_gap) begin
            m_gap = 0; m_done = 0; m_to = 0;
        end else if (m_granted) begin
            if (ack) begin
                m_granted = 0; m_gap = 1; m_done = 1;
            end else if (TO_EN && m_shown == HOLD) begin
                m_granted = 0; m_gap = 1; m_to = 1;
            end else begin
                m_shown++;
            end
        end else if (in_valid) begin
            m_granted = 1; m_idx = in_idx; m_shown = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_out",      {24'd0, out},       m_granted ? (32'd1 << m_idx) : 32'd0);
            check("m_busy",     {31'd0, busy},      {31'd0, m_granted | m_gap});
            check("m_ready",    {31'd0, in_ready},  {31'd0, ~(m_granted | m_gap)});
            check("m_done",     {31'd0, done},      {31'd0, m_done});
            check("m_timeout",  {31'd0, timeout},   {31'd0, m_to});
            if (m_granted | m_gap)
                check("m_grant_idx", {29'd0, grant_idx}, {29'd0, m_idx});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(); step();
        cmp_en = 1'b1;
        check("rst_out", {24'd0, out}, 32'h00);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_idx", {29'd0, grant_idx}, 32'd0);
        rst = 1'b0;

        // Idle with no request
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_out", {24'd0, out}, 32'h00);
            check("idle_ready", {31'd0, in_ready}, 32'd1);
        end

        // Index 5, ack in second grant cycle
        in_idx = 3'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("g5_out1", {24'd0, out}, 32'h20);
        check("g5_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("g5_out2", {24'd0, out}, 32'h20);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("g5_done", {31'd0, done}, 32'd1);
        check("g5_gap_out", {24'd0, out}, 32'h00);
        step();
        check("g5_done_off", {31'd0, done}, 32'd0);
        check("g5_ready_back", {31'd0, in_ready}, 32'd1);

        // Back-to-back 7 then 0, ack every grant cycle
        in_idx = 3'd7; in_valid = 1'b1; ack = 1'b1;
        step();
        check("b2b_out0", {24'd0, out}, 32'h80);
        in_idx = 3'd0;
        step();
        check("b2b_out1", {24'd0, out}, 32'h00);
        step();
        check("b2b_out2", {24'd0, out}, 32'h00);
        step();
        check("b2b_out3", {24'd0, out}, 32'h01);
        in_valid = 1'b0;
        step();
        step();
        ack = 1'b0;
        check("b2b_idle", {31'd0, in_ready}, 32'd1);

`ifdef GRANT_DECODER_TIMEOUT_EN
        // No ack: grant held exactly HOLD cycles, then timeout pulse
        in_idx = 3'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            check("to_out", {24'd0, out}, 32'h04);
            step();
        end
        check("to_out_clr", {24'd0, out}, 32'h00);
        check("to_pulse", {31'd0, timeout}, 32'd1);
        check("to_no_done", {31'd0, done}, 32'd0);
        step();
        check("to_pulse_off", {31'd0, timeout}, 32'd0);

        // Ack in the last allowed cycle beats the timeout
        in_idx = 3'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < HOLD - 1; i++) step();
        check("race_out", {24'd0, out}, 32'h08);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("race_done", {31'd0, done}, 32'd1);
        check("race_to", {31'd0, timeout}, 32'd0);
        step();
`else
        // No timeout: grant held indefinitely
        in_idx = 3'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) step();
        check("hold_out", {24'd0, out}, 32'h04);
        check("hold_to", {31'd0, timeout}, 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("hold_done", {31'd0, done}, 32'd1);
        step();
        check("hold_done_once", {31'd0, done}, 32'd0);
`endif

        // Reset in the second grant cycle, request held high
        in_idx = 3'd6; in_valid = 1'b1;
        step();
        check("rg_out1", {24'd0, out}, 32'h40);
        step();
        rst = 1'b1; ack = 1'b1;
        step();
        check("rg_out_clr", {24'd0, out}, 32'h00);
        check("rg_no_done", {31'd0, done}, 32'd0);
        check("rg_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0; ack = 1'b0;
        step();
        check("rg_reaccept", {24'd0, out}, 32'h40);
        in_valid = 1'b0; ack = 1'b1;
        step();
        check("rg_done", {31'd0, done}, 32'd1);
        ack = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Registered 3-to-8 grant decoder that closes the loop behind the 8-input priority encoder. It accepts the encoder's winning index plus its "any request active" flag, drives a one-hot grant line to the selected requester, and holds it until that requester acknowledges. A one-cycle gap follows every grant, so grants never overlap. An optional hold timeout is available at compile time.

## Interface
- HOLD_CYCLES, 4: maximum GRANT-state cycles before timeout; legal range 1..255; used only when the timeout is compiled in.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_idx  input  3  winning index from the encoder; 7 is the highest priority.
- in_valid  input  1  encoder priority flag; 1 means in_idx is meaningful.
- in_ready  output  1  decoder can accept an index this cycle; decoded from state.
- ack  input  1  acknowledge from the granted requester.
- out  output  8  one-hot grant; bit n is asserted for captured index n.
- grant_idx  output  3  captured index, held while busy.
- busy  output  1  asserted in the GRANT and GAP states.
- done  output  1  one-cycle pulse marking a grant ended by ack.
- timeout  output  1  one-cycle pulse marking a grant ended by timeout; tied to 0 when compiled out.

## Operation
- States:
  - IDLE: in_ready=1, out=0, busy=0.
  - GRANT: out=1<<grant_idx, busy=1, in_ready=0.
  - GAP: out=0, busy=1, in_ready=0.
- IDLE -> GRANT when in_valid=1 at a clock edge.
  - Captures in_idx into grant_idx.
  - Clears the hold counter.
- IDLE with in_valid=0: remain in IDLE, no change.
- GRANT -> GAP when ack=1 is sampled.
  - out clears.
  - done=1 for the GAP cycle only.
- GRANT -> GAP on timeout (macro present): taken when the counter equals HOLD_CYCLES-1 and ack=0.
  - timeout=1 for the GAP cycle only.
- ack and the timeout condition in the same cycle: ack wins, so done=1 and timeout=0.
- GRANT otherwise: remain in GRANT; the counter increments and saturates at HOLD_CYCLES-1.
- GAP -> IDLE unconditionally after one cycle.
- in_valid while busy: ignored and not queued. The encoder re-presents any request that is still pending.
- ack in IDLE or GAP: ignored.
- Hold counter width: $clog2(HOLD_CYCLES)+1 bits, unsigned, no wrap.
- Registered outputs: out, grant_idx, busy, done, timeout. in_ready is combinational from state only, with no input-to-output combinational path.

## Timing
- Reset values after a clock edge with rst=1:
  - State: IDLE.
  - out, grant_idx, busy, done, timeout, hold counter: all 0.
  - in_ready: 1.
- Reset mid-grant: rst overrides everything at the same edge.
  - out drops to 0 the following cycle.
  - No done or timeout pulse.
  - A pending ack is discarded.
- Latency: accept at edge E gives out valid from cycle E+1.
- Minimum grant length: 1 cycle (ack sampled in the first GRANT cycle).
- Maximum back-to-back rate: one grant every 3 cycles (GRANT, GAP, IDLE).
- Timeout, HOLD_CYCLES=N, no ack: out is high for exactly N cycles.
- HOLD_CYCLES=1: a single-cycle grant, unless ack arrives in that cycle.

## Configuration
- GRANT_DECODER_TIMEOUT_EN defined:
  - The hold counter and the timeout path are implemented.
  - The timeout port is driven as specified above.
- GRANT_DECODER_TIMEOUT_EN undefined:
  - No counter is instantiated; HOLD_CYCLES has no effect.
  - GRANT is left only via ack or rst; the grant is held indefinitely.
  - The timeout port is constant 0.

## Test plan
- Reset, then idle with in_valid=0 for 5 cycles: out=8'h00, busy=0, in_ready=1, done=0, timeout=0 throughout.
- in_idx=3'b101 with in_valid=1 at edge E, ack=1 in cycle E+2:
  - out=8'b0010_0000 in cycles E+1..E+2.
  - done=1 in cycle E+3 only; in_ready=1 again from E+4.
- Back-to-back indices 7 then 0, in_valid held high, ack=1 in every GRANT cycle:
  - out sequence 8'h80, 0, 0, 8'h01.
  - Second accept 3 cycles after the first.
- Timeout compiled in, HOLD_CYCLES=4, no ack:
  - out high for exactly 4 cycles, then timeout=1 for 1 cycle, done=0.
  - With ack asserted in the 4th GRANT cycle instead: done=1, timeout=0.
- Timeout compiled out, ack withheld for 300 cycles: out stays one-hot and timeout stays 0. Then ack=1: done pulses once.
- rst=1 during cycle 2 of a grant with in_valid=1:
  - out=0 the next cycle, no done pulse.
  - Decoder is in IDLE with in_ready=1.
  - Accepts again on the first edge after rst falls.
